instruction_memory_ctrl: RTL and testbench
==========================================

# instruction_memory_ctrl

Parametrised, synchronous-read program memory for the MIPS core that replaces the asynchronous ROM in the fetch stage. It translates byte addresses at a configurable base into word indices, returns instructions through a pipelined valid/ready fetch port with a selectable latency of 1 or 2 cycles, and flags misaligned and out-of-range fetches. A load port lets the test harness or boot logic write a program into the array at run time, so the array is not limited to a fixed image file.

## Interface
Parameters:
- MEMORY_DEPTH, 64: number of instruction words; must be a power of two, at least 2.
- DATA_WIDTH, 32: instruction width.
- ADDR_WIDTH, 32: fetch address width.
- BASE_ADDRESS, 32'h0040_0000: byte address of word 0.
- OUT_REG, 1: 0 gives a read latency of 1 cycle; 1 adds an output register, giving a latency of 2 cycles.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_valid  in  1  fetch request.
- fetch_ready  out  1  request can be accepted; combinational: (state==RUN) && !load_en.
- Address  in  ADDR_WIDTH  byte address of the fetch.
- instr_valid  out  1  Instruction and instr_fault are valid this cycle (single-cycle strobe).
- Instruction  out  DATA_WIDTH  fetched word; 0 (sll NOP) on a fault.
- instr_fault  out  2  2'b00 ok, 2'b01 misaligned, 2'b10 out of range.
- load_en  in  1  request or hold LOAD mode.
- load_valid  in  1  load_data is written this cycle (LOAD state only).
- load_data  in  DATA_WIDTH  word to write.
- load_busy  out  1  state==LOAD.
- load_words  out  $clog2(MEMORY_DEPTH)+1  number of words written in the last or current load.
- load_overflow  out  1  sticky; set when a word is written while the array is full; cleared on entry to LOAD.

## Operation
- States: RUN (after reset), DRAIN, LOAD.
- RUN: if load_en=1 → DRAIN. fetch_ready is already 0 in that cycle.
- DRAIN: stay until no fetch is in flight (all pipeline valid bits are 0), then → LOAD. On entry to LOAD: load_words cleared to 0 and load_overflow cleared to 0. If load_en drops while in DRAIN → RUN.
- LOAD: each load_valid=1 cycle with load_words<MEMORY_DEPTH writes rom[load_words] and increments load_words. If load_valid=1 while load_words==MEMORY_DEPTH, the data is discarded and load_overflow is set. load_en=0 → RUN; load_words holds its value.
- A fetch is accepted when fetch_valid && fetch_ready. Address is sampled that cycle. One accept per cycle is possible; the output side has no backpressure.
- Address decode: offset = Address − BASE_ADDRESS, with ADDR_WIDTH-bit unsigned arithmetic.
  - Misaligned if Address[1:0]≠0.
  - Out of range if Address<BASE_ADDRESS or offset[ADDR_WIDTH-1:2] ≥ MEMORY_DEPTH.
  - Index = offset[2 +: $clog2(MEMORY_DEPTH)].
  - If both fault conditions hold, the reported code is misaligned (01).
- On a faulting fetch, Instruction=0 and instr_valid still pulses at the normal latency.
- Reset does not clear the memory array. Its content after power-up is undefined unless loaded.

## Timing
- Reset values: state RUN, instr_valid 0, Instruction 0, instr_fault 00, load_words 0, load_overflow 0, load_busy 0. All pipeline valid bits are 0.
- Latency with OUT_REG=0: request accepted at edge N → instr_valid high in the cycle after edge N+1.
- Latency with OUT_REG=1: one cycle later than OUT_REG=0.
- Back-to-back accepts produce back-to-back instr_valid in request order.
- Instruction and instr_fault hold their last value when instr_valid=0.
- Entering LOAD after load_en rises takes 1 cycle plus the drain time:
  - with OUT_REG=1, at most 3 cycles;
  - if nothing is in flight, load_busy is high after 2 edges (RUN→DRAIN→LOAD).
- A write in LOAD is visible to a fetch accepted on any cycle after returning to RUN. No read-during-write case exists, because fetch and LOAD are exclusive.
- Reset asserted mid-operation:
  - in-flight fetches are dropped (no instr_valid);
  - a partial load is abandoned, and load_words and load_overflow return to 0;
  - words already written stay in the array.

## Test plan
- Load: load_en=1, write 0x2008000A, 0x200900FF, 0x01095020 → load_words=3. load_en=0, then fetch 0x00400000, 0x00400004, 0x00400008 back-to-back → three consecutive instr_valid with those words, fault 00, at latency 2 (OUT_REG=1); repeat with OUT_REG=0 and check latency 1.
- Faults: fetch 0x00400002 → Instruction 0, fault 01. Fetch 0x00400100 with depth 64 → fault 10. Fetch 0x003FFFFC → fault 10. Fetch 0x00400101 → fault 01.
- Overflow: with depth 4, write 5 words → load_words=4, load_overflow=1, rom[0..3] hold the first four words. Re-entering LOAD clears both load_words and load_overflow.
- Drain: issue 2 fetches, then raise load_en in the next cycle → fetch_ready=0 immediately; both instr_valid still arrive; load_busy rises only after the second result.
- Reset mid-fetch and mid-load: reset low with a fetch in flight → no instr_valid, all outputs at reset values. The previously loaded word at 0x00400000 still reads back correctly after reset.

Source files
------------

// File: rtl/instruction_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instruction_memory_ctrl
// Brief    : Synchronous-read program memory for the MIPS fetch stage. Byte
//            addresses are translated from BASE_ADDRESS into word indices, and
//            instructions return through a pipelined valid/ready port with a
//            latency of 1 (OUT_REG=0) or 2 (OUT_REG=1) cycles. Misaligned and
//            out-of-range fetches return a NOP with a fault code. A load port
//            writes a program into the array at run time.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_memory_ctrl #(
  parameter int                    MEMORY_DEPTH = 64,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000,
  parameter int                    OUT_REG      = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // fetch port
  input  logic                          i_fetch_valid,
  output logic                          o_fetch_ready,
  input  logic [ADDR_WIDTH-1:0]         i_address,
  output logic                          o_instr_valid,
  output logic [DATA_WIDTH-1:0]         o_instruction,
  output logic [1:0]                    o_instr_fault,
  // load port
  input  logic                          i_load_en,
  input  logic                          i_load_valid,
  input  logic [DATA_WIDTH-1:0]         i_load_data,
  output logic                          o_load_busy,
  output logic [$clog2(MEMORY_DEPTH):0] o_load_words,
  output logic                          o_load_overflow
);

  localparam int IW = $clog2(MEMORY_DEPTH);
  localparam int LW = IW + 1;

  localparam logic [LW-1:0]         c_DEPTH_LW       = LW'(MEMORY_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_DEPTH_AW       = ADDR_WIDTH'(MEMORY_DEPTH);
  localparam logic [1:0]            c_FAULT_OK       = 2'b00;
  localparam logic [1:0]            c_FAULT_MISALIGN = 2'b01;
  localparam logic [1:0]            c_FAULT_RANGE    = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  state_t                r_state;
  logic                  r_load_busy;
  logic [LW-1:0]         r_load_words;
  logic                  r_load_overflow;

  logic [DATA_WIDTH-1:0] r_rom [MEMORY_DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  r_s1_valid;
  logic [1:0]            r_s1_fault;

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_instr;
  logic [1:0]            r_out_fault;

  logic [ADDR_WIDTH-1:0] w_offset;
  logic [ADDR_WIDTH-1:0] w_word_off;
  logic                  w_misaligned;
  logic                  w_out_of_range;
  logic [IW-1:0]         w_index;
  logic [1:0]            w_fault;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_array_full;
  logic                  w_write;
  logic                  w_pipe_busy;
  logic [DATA_WIDTH-1:0] w_s1_instr;

  // --------------------------------------------------------------------------
  // Address decode: byte address -> word index plus fault classification.
  // Misalignment takes priority over out-of-range when both apply.
  // --------------------------------------------------------------------------
  assign w_offset       = i_address - BASE_ADDRESS;
  assign w_word_off     = w_offset >> 2;
  assign w_misaligned   = |i_address[1:0];
  assign w_out_of_range = (i_address < BASE_ADDRESS) || (w_word_off >= c_DEPTH_AW);
  assign w_index        = w_word_off[IW-1:0];
  assign w_fault        = w_misaligned   ? c_FAULT_MISALIGN :
                          w_out_of_range ? c_FAULT_RANGE    : c_FAULT_OK;

  // Fetches are refused as soon as a load is requested so the pipe can drain.
  assign w_ready      = (r_state == ST_RUN) && !i_load_en;
  assign w_accept     = i_fetch_valid && w_ready;

  assign w_array_full = (r_load_words == c_DEPTH_LW);
  assign w_write      = (r_state == ST_LOAD) && i_load_valid && !w_array_full;

  // --------------------------------------------------------------------------
  // Control FSM: RUN -> DRAIN (wait for in-flight fetches) -> LOAD, with the
  // load counter and sticky overflow flag kept alongside the state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_RUN;
      r_load_busy     <= 1'b0;
      r_load_words    <= '0;
      r_load_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_load_en) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!i_load_en) begin
            r_state <= ST_RUN;
          end else if (!w_pipe_busy) begin
            r_state         <= ST_LOAD;
            r_load_busy     <= 1'b1;
            r_load_words    <= '0;
            r_load_overflow <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (i_load_valid) begin
            if (w_array_full) begin
              r_load_overflow <= 1'b1;
            end else begin
              r_load_words <= r_load_words + LW'(1);
            end
          end
          if (!i_load_en) begin
            r_state     <= ST_RUN;
            r_load_busy <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_RUN;
          r_load_busy <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Storage array: load-port writes and synchronous fetch read. Not reset, so
  // a program survives a reset of the controller.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_rom[r_load_words[IW-1:0]] <= i_load_data;
    end
    if (w_accept) begin
      r_rd_data <= r_rom[w_index];
    end
  end

  // First pipeline stage: request valid and fault code alongside the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_fault <= c_FAULT_OK;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_fault <= w_fault;
      end
    end
  end

  // A faulting fetch returns an all-zero word (sll $0,$0,0 = NOP).
  assign w_s1_instr = (r_s1_fault == c_FAULT_OK) ? r_rd_data : '0;

  // --------------------------------------------------------------------------
  // Output stage(s). The visible outputs only update on a valid result so
  // Instruction and instr_fault hold between strobes.
  // --------------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_out_reg
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_s2_instr;
    logic [1:0]            r_s2_fault;

    // Extra register stage between the array read and the port.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s2_valid <= 1'b0;
        r_s2_instr <= '0;
        r_s2_fault <= c_FAULT_OK;
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_instr <= w_s1_instr;
          r_s2_fault <= r_s1_fault;
        end
      end
    end

    // Port register fed from the extra stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out_valid <= 1'b0;
        r_out_instr <= '0;
        r_out_fault <= c_FAULT_OK;
      end else begin
        r_out_valid <= r_s2_valid;
        if (r_s2_valid) begin
          r_out_instr <= r_s2_instr;
          r_out_fault <= r_s2_fault;
        end
      end
    end

    assign w_pipe_busy = r_s1_valid | r_s2_valid;
  end else begin : g_no_out_reg
    // Port register fed directly from the read stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out_valid <= 1'b0;
        r_out_instr <= '0;
        r_out_fault <= c_FAULT_OK;
      end else begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_instr <= w_s1_instr;
          r_out_fault <= r_s1_fault;
        end
      end
    end

    assign w_pipe_busy = r_s1_valid;
  end

  // --------------------------------------------------------------------------
  // Port mapping
  // --------------------------------------------------------------------------
  assign o_fetch_ready   = w_ready;
  assign o_instr_valid   = r_out_valid;
  assign o_instruction   = r_out_instr;
  assign o_instr_fault   = r_out_fault;
  assign o_load_busy     = r_load_busy;
  assign o_load_words    = r_load_words;
  assign o_load_overflow = r_load_overflow;

endmodule

`default_nettype wire

// File: tb/tb_instruction_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_memory_ctrl
// Brief    : Self-checking bench. Two instances share all inputs:
//            dut 0 = depth 64, OUT_REG=1 (latency 2); dut 1 = depth 4,
//            OUT_REG=0 (latency 1). Results are compared against a
//            word-array reference model of the program memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_memory_ctrl;

  localparam int          DEPTH_A = 64;
  localparam int          DEPTH_B = 4;
  localparam logic [31:0] BASE    = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  fault;
    logic [31:0] cyc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid, load_en, load_valid;
  logic [31:0] address, load_data;

  logic        a_ready, a_ivalid, a_busy, a_ovf;
  logic [31:0] a_instr;
  logic [1:0]  a_fault;
  logic [6:0]  a_words;
  logic        b_ready, b_ivalid, b_busy, b_ovf;
  logic [31:0] b_instr;
  logic [1:0]  b_fault;
  logic [2:0]  b_words;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  logic [31:0] mem_a [DEPTH_A];
  logic [31:0] mem_b [DEPTH_B];
  int          cnt [2];
  bit          ovf [2];
  res_t        got [2][$];
  res_t        exp [2][$];

  instruction_memory_ctrl #(
    .MEMORY_DEPTH(DEPTH_A), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .BASE_ADDRESS(BASE), .OUT_REG(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_fetch_valid(fetch_valid), .o_fetch_ready(a_ready), .i_address(address),
    .o_instr_valid(a_ivalid), .o_instruction(a_instr), .o_instr_fault(a_fault),
    .i_load_en(load_en), .i_load_valid(load_valid), .i_load_data(load_data),
    .o_load_busy(a_busy), .o_load_words(a_words), .o_load_overflow(a_ovf)
  );

  instruction_memory_ctrl #(
    .MEMORY_DEPTH(DEPTH_B), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .BASE_ADDRESS(BASE), .OUT_REG(0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_fetch_valid(fetch_valid), .o_fetch_ready(b_ready), .i_address(address),
    .o_instr_valid(b_ivalid), .o_instruction(b_instr), .o_instr_fault(b_fault),
    .i_load_en(load_en), .i_load_valid(load_valid), .i_load_data(load_data),
    .o_load_busy(b_busy), .o_load_words(b_words), .o_load_overflow(b_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // result monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (a_ivalid) got[0].push_back({a_instr, a_fault, 32'(cyc)});
    if (b_ivalid) got[1].push_back({b_instr, b_fault, 32'(cyc)});
  end

  // --------------------------------------------------------------------------
  // Reference model: result of a fetch accepted in cycle acc
  // --------------------------------------------------------------------------
  function automatic res_t model_fetch(input logic [31:0] addr, input int d, input int acc);
    res_t r;
    int   depth;
    int   lat;
    depth = (d == 0) ? DEPTH_A : DEPTH_B;
    lat   = (d == 0) ? 2 : 1;
    r.cyc = 32'(acc + lat);
    r.instr = 32'h0;
    if (addr % 4 != 0) begin
      r.fault = 2'b01;
    end else if (addr < BASE || (addr - BASE) / 4 >= 32'(depth)) begin
      r.fault = 2'b10;
    end else begin
      r.fault = 2'b00;
      r.instr = (d == 0) ? mem_a[int'((addr - BASE) / 4)] : mem_b[int'((addr - BASE) / 4)];
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus drivers (no checking here)
  // --------------------------------------------------------------------------
  task automatic sb_clear();
    for (int d = 0; d < 2; d++) begin
      got[d].delete();
      exp[d].delete();
    end
  endtask

  task automatic issue_fetch(input logic [31:0] addr);
    int acc;
    @(negedge clk);
    fetch_valid = 1'b1;
    address     = addr;
    acc         = cyc + 1;
    for (int d = 0; d < 2; d++) exp[d].push_back(model_fetch(addr, d, acc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fetch_valid = 1'b0;
    end
  endtask

  task automatic enter_load();
    @(negedge clk);
    fetch_valid = 1'b0;
    load_en     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0;
      ovf[d] = 1'b0;
    end
  endtask

  task automatic write_word(input logic [31:0] w);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = w;
    if (cnt[0] < DEPTH_A) begin mem_a[cnt[0]] = w; cnt[0]++; end else ovf[0] = 1'b1;
    if (cnt[1] < DEPTH_B) begin mem_b[cnt[1]] = w; cnt[1]++; end else ovf[1] = 1'b1;
  endtask

  task automatic exit_load();
    @(negedge clk);
    load_valid = 1'b0;
    load_en    = 1'b0;
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({a_ivalid, a_instr, a_fault, a_words, a_ovf, a_busy} !== '0) begin
      errors++;
      $display("FAIL reset dut0 got v=%b i=%h f=%b w=%0d o=%b b=%b exp all 0",
               a_ivalid, a_instr, a_fault, a_words, a_ovf, a_busy);
    end
    checks++;
    if ({b_ivalid, b_instr, b_fault, b_words, b_ovf, b_busy} !== '0) begin
      errors++;
      $display("FAIL reset dut1 got v=%b i=%h f=%b w=%0d o=%b b=%b exp all 0",
               b_ivalid, b_instr, b_fault, b_words, b_ovf, b_busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_ready, b_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready got %b%b exp 11", a_ready, b_ready);
    end
  endtask

  task automatic test_load();
    logic [31:0] prog [3];
    prog[0] = 32'h2008_000A;
    prog[1] = 32'h2009_00FF;
    prog[2] = 32'h0109_5020;
    enter_load();
    checks++;
    if ({a_busy, b_busy} !== 2'b11) begin
      errors++;
      $display("FAIL load_busy_entry got %b%b exp 11", a_busy, b_busy);
    end
    for (int i = 0; i < 3; i++) write_word(prog[i]);
    exit_load();
    checks++;
    if (a_words !== 7'(cnt[0]) || b_words !== 3'(cnt[1]) || {a_busy, b_busy} !== 2'b00) begin
      errors++;
      $display("FAIL load_words got %0d/%0d busy %b%b exp %0d/%0d busy 00",
               a_words, b_words, a_busy, b_busy, cnt[0], cnt[1]);
    end
    sb_clear();
    for (int i = 0; i < 3; i++) issue_fetch(BASE + 32'(4 * i));
    idle(6);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got[d].size() != exp[d].size()) begin
        errors++;
        $display("FAIL load_fetch dut%0d count got %0d exp %0d", d, got[d].size(), exp[d].size());
      end
      for (int i = 0; i < exp[d].size() && i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp[d][i]) begin
          errors++;
          $display("FAIL load_fetch dut%0d[%0d] got %h/%b@%0d exp %h/%b@%0d", d, i,
                   got[d][i].instr, got[d][i].fault, got[d][i].cyc,
                   exp[d][i].instr, exp[d][i].fault, exp[d][i].cyc);
        end
      end
    end
  endtask

  task automatic test_faults();
    logic [31:0] addrs [8];
    addrs[0] = 32'h0040_0002; addrs[1] = 32'h0040_0100;
    addrs[2] = 32'h003F_FFFC; addrs[3] = 32'h0040_0101;
    addrs[4] = 32'h0040_0004; addrs[5] = 32'hFFFF_FFFC;
    addrs[6] = 32'h0000_0000; addrs[7] = 32'h0040_0008;
    sb_clear();
    for (int i = 0; i < 8; i++) begin
      issue_fetch(addrs[i]);
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(6);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got[d].size() != exp[d].size()) begin
        errors++;
        $display("FAIL faults dut%0d count got %0d exp %0d", d, got[d].size(), exp[d].size());
      end
      for (int i = 0; i < exp[d].size() && i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp[d][i]) begin
          errors++;
          $display("FAIL faults dut%0d[%0d] got %h/%b@%0d exp %h/%b@%0d", d, i,
                   got[d][i].instr, got[d][i].fault, got[d][i].cyc,
                   exp[d][i].instr, exp[d][i].fault, exp[d][i].cyc);
        end
      end
    end
  endtask

  task automatic test_overflow();
    enter_load();
    checks++;
    if (a_words !== 7'd0 || b_words !== 3'd0 || {a_ovf, b_ovf} !== 2'b00) begin
      errors++;
      $display("FAIL ovf_entry got %0d/%0d ovf %b%b exp 0/0 ovf 00", a_words, b_words, a_ovf, b_ovf);
    end
    for (int i = 0; i < 5; i++) write_word($urandom);
    exit_load();
    checks++;
    if (a_words !== 7'(cnt[0]) || b_words !== 3'(cnt[1]) || {a_ovf, b_ovf} !== {ovf[0], ovf[1]}) begin
      errors++;
      $display("FAIL ovf_count got %0d/%0d ovf %b%b exp %0d/%0d ovf %b%b",
               a_words, b_words, a_ovf, b_ovf, cnt[0], cnt[1], ovf[0], ovf[1]);
    end
    sb_clear();
    for (int i = 0; i < 5; i++) issue_fetch(BASE + 32'(4 * i));
    idle(6);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got[d].size() != exp[d].size()) begin
        errors++;
        $display("FAIL ovf_fetch dut%0d count got %0d exp %0d", d, got[d].size(), exp[d].size());
      end
      for (int i = 0; i < exp[d].size() && i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp[d][i]) begin
          errors++;
          $display("FAIL ovf_fetch dut%0d[%0d] got %h/%b@%0d exp %h/%b@%0d", d, i,
                   got[d][i].instr, got[d][i].fault, got[d][i].cyc,
                   exp[d][i].instr, exp[d][i].fault, exp[d][i].cyc);
        end
      end
    end
    // re-entering LOAD clears the counter and the sticky flag
    enter_load();
    checks++;
    if (a_words !== 7'd0 || b_words !== 3'd0 || {a_ovf, b_ovf} !== 2'b00) begin
      errors++;
      $display("FAIL ovf_reentry got %0d/%0d ovf %b%b exp 0/0 ovf 00", a_words, b_words, a_ovf, b_ovf);
    end
    exit_load();
  endtask

  task automatic test_drain();
    int acc_last;
    int busy_cyc [2];
    int exp_busy;
    sb_clear();
    issue_fetch(BASE);
    issue_fetch(BASE + 32'd4);
    acc_last = cyc + 1;
    @(negedge clk);
    fetch_valid = 1'b0;
    load_en     = 1'b1;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b00) begin
      errors++;
      $display("FAIL drain_ready got %b%b exp 00", a_ready, b_ready);
    end
    busy_cyc[0] = -1;
    busy_cyc[1] = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (a_busy && busy_cyc[0] < 0) busy_cyc[0] = cyc;
      if (b_busy && busy_cyc[1] < 0) busy_cyc[1] = cyc;
    end
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0;
      ovf[d] = 1'b0;
      // one edge to DRAIN, one more to LOAD, and never before the last result
      exp_busy = acc_last + 2;
      if (int'(exp[d][exp[d].size() - 1].cyc) + 1 > exp_busy)
        exp_busy = int'(exp[d][exp[d].size() - 1].cyc) + 1;
      checks++;
      if (busy_cyc[d] != exp_busy) begin
        errors++;
        $display("FAIL drain_busy dut%0d got cycle %0d exp cycle %0d", d, busy_cyc[d], exp_busy);
      end
    end
    exit_load();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got[d].size() != exp[d].size()) begin
        errors++;
        $display("FAIL drain_fetch dut%0d count got %0d exp %0d", d, got[d].size(), exp[d].size());
      end
      for (int i = 0; i < exp[d].size() && i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp[d][i]) begin
          errors++;
          $display("FAIL drain_fetch dut%0d[%0d] got %h/%b@%0d exp %h/%b@%0d", d, i,
                   got[d][i].instr, got[d][i].fault, got[d][i].cyc,
                   exp[d][i].instr, exp[d][i].fault, exp[d][i].cyc);
        end
      end
    end
  endtask

  task automatic test_random();
    int          n;
    int          k;
    int          kind;
    logic [31:0] addr;
    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(1, 70);
      enter_load();
      for (int i = 0; i < n; i++) write_word($urandom);
      exit_load();
      checks++;
      if (a_words !== 7'(cnt[0]) || b_words !== 3'(cnt[1]) || {a_ovf, b_ovf} !== {ovf[0], ovf[1]}) begin
        errors++;
        $display("FAIL rand_load it%0d got %0d/%0d ovf %b%b exp %0d/%0d ovf %b%b", it,
                 a_words, b_words, a_ovf, b_ovf, cnt[0], cnt[1], ovf[0], ovf[1]);
      end
      sb_clear();
      for (int i = 0; i < 20; i++) begin
        kind = $urandom_range(0, 9);
        k    = $urandom_range(0, n - 1);
        if (kind == 0)      addr = BASE + 32'(4 * k) + 32'($urandom_range(1, 3));
        else if (kind == 1) addr = BASE - 32'(4 * $urandom_range(1, 1000));
        else if (kind == 2) addr = BASE + 32'(4 * (DEPTH_A + $urandom_range(0, 1000)));
        else                addr = BASE + 32'(4 * k);
        issue_fetch(addr);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(6);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (got[d].size() != exp[d].size()) begin
          errors++;
          $display("FAIL rand_fetch dut%0d count got %0d exp %0d", d, got[d].size(), exp[d].size());
        end
        for (int i = 0; i < exp[d].size() && i < got[d].size(); i++) begin
          checks++;
          if (got[d][i] !== exp[d][i]) begin
            errors++;
            $display("FAIL rand_fetch dut%0d[%0d] got %h/%b@%0d exp %h/%b@%0d", d, i,
                     got[d][i].instr, got[d][i].fault, got[d][i].cyc,
                     exp[d][i].instr, exp[d][i].fault, exp[d][i].cyc);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    // reset with a fetch in flight: result is dropped
    sb_clear();
    issue_fetch(BASE);
    @(negedge clk);
    fetch_valid = 1'b0;
    rst_n       = 1'b0;
    #1;
    checks++;
    if ({a_ivalid, a_instr, a_fault, a_words, a_ovf, a_busy, b_ivalid, b_instr, b_fault,
         b_words, b_ovf, b_busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_fetch outputs got %b/%h/%0d %b/%h/%0d exp all 0",
               a_ivalid, a_instr, a_words, b_ivalid, b_instr, b_words);
    end
    for (int d = 0; d < 2; d++) exp[d].delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    checks++;
    if (got[0].size() != 0 || got[1].size() != 0) begin
      errors++;
      $display("FAIL reset_mid_drop got %0d/%0d results exp 0/0", got[0].size(), got[1].size());
    end
    // reset in the middle of a load: counter cleared, written words kept
    enter_load();
    write_word($urandom);
    write_word($urandom);
    @(negedge clk);
    load_valid = 1'b0;
    load_en    = 1'b0;
    rst_n      = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0;
      ovf[d] = 1'b0;
    end
    #1;
    checks++;
    if (a_words !== 7'd0 || b_words !== 3'd0 || {a_ovf, b_ovf, a_busy, b_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_load got %0d/%0d ovf %b%b busy %b%b exp 0/0 ovf 00 busy 00",
               a_words, b_words, a_ovf, b_ovf, a_busy, b_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb_clear();
    issue_fetch(BASE);
    issue_fetch(BASE + 32'd4);
    idle(6);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got[d].size() != exp[d].size()) begin
        errors++;
        $display("FAIL reset_mid_keep dut%0d count got %0d exp %0d", d, got[d].size(), exp[d].size());
      end
      for (int i = 0; i < exp[d].size() && i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp[d][i]) begin
          errors++;
          $display("FAIL reset_mid_keep dut%0d[%0d] got %h/%b@%0d exp %h/%b@%0d", d, i,
                   got[d][i].instr, got[d][i].fault, got[d][i].cyc,
                   exp[d][i].instr, exp[d][i].fault, exp[d][i].cyc);
        end
      end
    end
  endtask

  initial begin
    fetch_valid = 1'b0;
    load_en     = 1'b0;
    load_valid  = 1'b0;
    address     = 32'h0;
    load_data   = 32'h0;
    cnt[0] = 0; cnt[1] = 0;
    ovf[0] = 1'b0; ovf[1] = 1'b0;
    test_reset();
    test_load();
    test_faults();
    test_overflow();
    test_drain();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
